// File: rtl/chan_scan_ctrl_pkg.sv
// Shared state encoding, default widths and width helpers for the channel
// scan scheduler and its channel table.
package chan_scan_ctrl_pkg;

    localparam int DEF_PHASE_WIDTH = 32;
    localparam int DEF_DEMOD_WIDTH = 12;
    localparam int DEF_CHAN_NUM    = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TUNE     = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_DWELL    = 3'd3,
        ST_LOCK     = 3'd4,
        ST_GUARD_TX = 3'd5,
        ST_TX       = 3'd6,
        ST_GUARD_RX = 3'd7
    } state_t;

    // Channel index width; a single-entry table still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Shared counter width, large enough to hold the longest interval.
    function automatic int cnt_width(input int dwell, input int hang, input int guard);
        int m;
        m = (dwell > hang) ? dwell : hang;
        m = (m > guard) ? m : guard;
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/chan_scan_ctrl_if.sv
// Control/status bundle between the host/modem side and the channel scan
// scheduler: table writes, scan/PTT requests, squelch input and tuning outputs.
interface chan_scan_ctrl_if
    import chan_scan_ctrl_pkg::*;
#(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int DEMOD_WIDTH = DEF_DEMOD_WIDTH,
    parameter int CHAN_NUM    = DEF_CHAN_NUM
);
    localparam int IDX_W = idx_width(CHAN_NUM);

    logic                   chan_we;
    logic [IDX_W-1:0]       chan_addr;
    logic [PHASE_WIDTH-1:0] chan_fre;
    logic                   scan_en;
    logic                   ptt;
    logic [DEMOD_WIDTH-1:0] squelch_thr;
    logic [DEMOD_WIDTH-1:0] demod_in;
    logic [PHASE_WIDTH-1:0] Fre_word;
    logic                   cfg_strobe;
    logic                   rx_en;
    logic                   tx_en;
    logic [IDX_W-1:0]       chan_idx;
    logic                   locked;

    modport master (
        output chan_we, chan_addr, chan_fre, scan_en, ptt, squelch_thr, demod_in,
        input  Fre_word, cfg_strobe, rx_en, tx_en, chan_idx, locked
    );

    modport slave (
        input  chan_we, chan_addr, chan_fre, scan_en, ptt, squelch_thr, demod_in,
        output Fre_word, cfg_strobe, rx_en, tx_en, chan_idx, locked
    );

endinterface

// File: rtl/chan_scan_ctrl_chan_table.sv
// Channel table: CHAN_NUM frequency words, synchronous write with
// out-of-range addresses dropped, combinational read, synchronous clear.
module chan_table
    import chan_scan_ctrl_pkg::*;
#(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int CHAN_NUM    = DEF_CHAN_NUM,
    localparam int IDX_W      = idx_width(CHAN_NUM)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   we_i,
    input  logic [IDX_W-1:0]       addr_i,
    input  logic [PHASE_WIDTH-1:0] data_i,
    input  logic [IDX_W-1:0]       rd_addr_i,
    output logic [PHASE_WIDTH-1:0] rd_data_o
);
    localparam logic [IDX_W:0] DEPTH = (IDX_W + 1)'(CHAN_NUM);

    logic [PHASE_WIDTH-1:0] mem_q [CHAN_NUM];
    logic                   wr_ok_s;
    logic                   rd_ok_s;

    assign wr_ok_s = ({1'b0, addr_i} < DEPTH);
    assign rd_ok_s = ({1'b0, rd_addr_i} < DEPTH);

    // Table storage with synchronous clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < CHAN_NUM; i++) begin
                mem_q[i] <= {PHASE_WIDTH{1'b0}};
            end
        end else if (we_i && wr_ok_s) begin
            mem_q[addr_i] <= data_i;
        end
    end

    assign rd_data_o = rd_ok_s ? mem_q[rd_addr_i] : {PHASE_WIDTH{1'b0}};

endmodule

// File: rtl/chan_scan_ctrl.sv
// Half-duplex channel scheduler: scans the channel table with carrier
// squelch, locks on activity and hands the shared modem to TX on PTT.
module chan_scan_ctrl
    import chan_scan_ctrl_pkg::*;
#(
    parameter int PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int DEMOD_WIDTH = DEF_DEMOD_WIDTH,
    parameter int CHAN_NUM    = DEF_CHAN_NUM,
    parameter int DWELL_CYC   = 1000,
    parameter int GUARD_CYC   = 16,
    parameter int HANG_CYC    = 5000
) (
    input  logic            clk_in,
    input  logic            RST,
    chan_scan_ctrl_if.slave bus
);
    localparam int IDX_W = idx_width(CHAN_NUM);
    localparam int CNT_W = cnt_width(DWELL_CYC, HANG_CYC, GUARD_CYC);

    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL_CYC);
    localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYC);
    localparam logic [CNT_W-1:0] HANG_LD  = CNT_W'(HANG_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHAN_NUM - 1);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       chan_idx_q, chan_idx_d;
    logic                   lock_mem_q, lock_mem_d;
    logic [PHASE_WIDTH-1:0] fre_word_q;
    logic                   cfg_strobe_q;
    logic                   rx_en_q;
    logic                   tx_en_q;
    logic                   locked_q;

    logic [PHASE_WIDTH-1:0] tbl_rd_s;
    logic [DEMOD_WIDTH-1:0] demod_s;
    logic [DEMOD_WIDTH-1:0] thr_s;
    logic [IDX_W-1:0]       chan_next_s;
    logic                   ptt_s;
    logic                   scan_en_s;
    logic                   carrier_s;
    logic                   rx_state_s;
    logic                   cnt_last_s;
    logic                   load_fre_s;

    chan_table #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .CHAN_NUM    (CHAN_NUM)
    ) u_chan_table (
        .clk_i     (clk_in),
        .rst_i     (RST),
        .we_i      (bus.chan_we),
        .addr_i    (bus.chan_addr),
        .data_i    (bus.chan_fre),
        .rd_addr_i (chan_idx_q),
        .rd_data_o (tbl_rd_s)
    );

    assign demod_s     = bus.demod_in;
    assign thr_s       = bus.squelch_thr;
    assign ptt_s       = bus.ptt;
    assign scan_en_s   = bus.scan_en;
    assign carrier_s   = (demod_s >= thr_s);
    assign cnt_last_s  = (cnt_q <= CNT_ONE);
    assign chan_next_s = (chan_idx_q >= IDX_LAST) ? {IDX_W{1'b0}} : (chan_idx_q + IDX_W'(1));
    assign rx_state_s  = (state_q == ST_TUNE) || (state_q == ST_SETTLE) ||
                         (state_q == ST_DWELL) || (state_q == ST_LOCK);

    // Next state, interval counter, channel advance and lock memory.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        chan_idx_d = chan_idx_q;
        lock_mem_d = lock_mem_q;
        load_fre_s = 1'b0;
        // PTT beats every receive-side event, so no channel advance on the same edge.
        if (rx_state_s && ptt_s) begin
            state_d    = ST_GUARD_TX;
            cnt_d      = GUARD_LD;
            lock_mem_d = (state_q == ST_LOCK);
        end else if (rx_state_s && !scan_en_s) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ptt_s) begin
                        state_d    = ST_GUARD_TX;
                        cnt_d      = GUARD_LD;
                        lock_mem_d = 1'b0;
                    end else if (scan_en_s) begin
                        state_d = ST_TUNE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_TUNE: begin
                    load_fre_s = 1'b1;
                    state_d    = ST_SETTLE;
                    cnt_d      = GUARD_LD;
                end
                ST_SETTLE: begin
                    if (cnt_last_s) begin
                        state_d = ST_DWELL;
                        cnt_d   = DWELL_LD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_DWELL: begin
                    if (carrier_s) begin
                        state_d = ST_LOCK;
                        cnt_d   = HANG_LD;
                    end else if (cnt_last_s) begin
                        state_d    = ST_TUNE;
                        cnt_d      = CNT_ZERO;
                        chan_idx_d = chan_next_s;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_LOCK: begin
                    if (carrier_s) begin
                        cnt_d = HANG_LD;
                    end else if (cnt_last_s) begin
                        state_d    = ST_TUNE;
                        cnt_d      = CNT_ZERO;
                        chan_idx_d = chan_next_s;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_GUARD_TX: begin
                    if (cnt_last_s) begin
                        state_d    = ST_TX;
                        cnt_d      = CNT_ZERO;
                        load_fre_s = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                ST_TX: begin
                    if (!ptt_s) begin
                        state_d = ST_GUARD_RX;
                        cnt_d   = GUARD_LD;
                    end else begin
                        state_d = ST_TX;
                    end
                end
                ST_GUARD_RX: begin
                    if (!cnt_last_s) begin
                        cnt_d = cnt_q - CNT_ONE;
                    end else if (ptt_s) begin
                        state_d = ST_GUARD_TX;
                        cnt_d   = GUARD_LD;
                    end else if (scan_en_s && lock_mem_q) begin
                        state_d = ST_LOCK;
                        cnt_d   = HANG_LD;
                    end else if (scan_en_s) begin
                        state_d = ST_SETTLE;
                        cnt_d   = GUARD_LD;
                    end else begin
                        state_d    = ST_IDLE;
                        cnt_d      = CNT_ZERO;
                        lock_mem_d = 1'b0;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    cnt_d      = CNT_ZERO;
                    lock_mem_d = 1'b0;
                end
            endcase
        end
    end

    // State, counters and output registers; outputs track the state being entered.
    always_ff @(posedge clk_in) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            cnt_q        <= CNT_ZERO;
            chan_idx_q   <= {IDX_W{1'b0}};
            lock_mem_q   <= 1'b0;
            fre_word_q   <= {PHASE_WIDTH{1'b0}};
            cfg_strobe_q <= 1'b0;
            rx_en_q      <= 1'b0;
            tx_en_q      <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            chan_idx_q   <= chan_idx_d;
            lock_mem_q   <= lock_mem_d;
            cfg_strobe_q <= load_fre_s;
            if (load_fre_s) begin
                fre_word_q <= tbl_rd_s;
            end
            rx_en_q  <= (state_d == ST_SETTLE) || (state_d == ST_DWELL) || (state_d == ST_LOCK);
            tx_en_q  <= (state_d == ST_TX);
            locked_q <= (state_d == ST_LOCK);
        end
    end

    assign bus.Fre_word   = fre_word_q;
    assign bus.cfg_strobe = cfg_strobe_q;
    assign bus.rx_en      = rx_en_q;
    assign bus.tx_en      = tx_en_q;
    assign bus.chan_idx   = chan_idx_q;
    assign bus.locked     = locked_q;

endmodule

// File: tb/tb_chan_scan_ctrl.sv
// Bench for chan_scan_ctrl: directed scenarios followed by random stimulus,
// every cycle compared against a phase/elapsed-time reference model.
module tb_chan_scan_ctrl;

    localparam int PW    = 32;
    localparam int DW    = 12;
    localparam int CN    = 4;
    localparam int DWELL = 8;
    localparam int GUARD = 2;
    localparam int HANG  = 4;

    localparam int P_IDLE   = 0;
    localparam int P_TUNE   = 1;
    localparam int P_SETTLE = 2;
    localparam int P_DWELL  = 3;
    localparam int P_LOCK   = 4;
    localparam int P_GTX    = 5;
    localparam int P_TX     = 6;
    localparam int P_GRX    = 7;

    logic clk_in = 1'b0;
    logic RST;

    chan_scan_ctrl_if #(.PHASE_WIDTH(PW), .DEMOD_WIDTH(DW), .CHAN_NUM(CN)) bus ();

    chan_scan_ctrl #(
        .PHASE_WIDTH (PW),
        .DEMOD_WIDTH (DW),
        .CHAN_NUM    (CN),
        .DWELL_CYC   (DWELL),
        .GUARD_CYC   (GUARD),
        .HANG_CYC    (HANG)
    ) dut (
        .clk_in (clk_in),
        .RST    (RST),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    logic [31:0] tbl_init [CN] = '{32'd459561501, 32'd459600000, 32'd459700000, 32'd459800000};

    // Reference model: current phase, cycles spent in it, quiet cycles in lock.
    int          m_phase;
    int          m_age;
    int          m_quiet;
    int          m_chan;
    logic [31:0] m_fre;
    logic        m_strobe;
    logic        m_lockmem;
    logic [31:0] m_table [CN];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic void go(input int p);
        m_phase = p;
        m_age   = 0;
    endfunction

    function automatic void advance_chan();
        m_chan = (m_chan + 1) % CN;
    endfunction

    function automatic void model_step();
        logic carrier;
        logic rx_phase;
        if (RST) begin
            go(P_IDLE);
            m_quiet   = 0;
            m_chan    = 0;
            m_fre     = 32'd0;
            m_strobe  = 1'b0;
            m_lockmem = 1'b0;
            for (int i = 0; i < CN; i++) m_table[i] = 32'd0;
            return;
        end
        carrier  = (bus.demod_in >= bus.squelch_thr);
        rx_phase = (m_phase >= P_TUNE) && (m_phase <= P_LOCK);
        m_strobe = 1'b0;
        m_age++;
        if (rx_phase && bus.ptt) begin
            m_lockmem = (m_phase == P_LOCK);
            go(P_GTX);
        end else if (rx_phase && !bus.scan_en) begin
            go(P_IDLE);
        end else begin
            case (m_phase)
                P_IDLE: begin
                    if (bus.ptt) begin m_lockmem = 1'b0; go(P_GTX); end
                    else if (bus.scan_en) go(P_TUNE);
                end
                P_TUNE: begin
                    m_fre = m_table[m_chan]; m_strobe = 1'b1; go(P_SETTLE);
                end
                P_SETTLE: if (m_age >= GUARD) go(P_DWELL);
                P_DWELL: begin
                    if (carrier) begin m_quiet = 0; go(P_LOCK); end
                    else if (m_age >= DWELL) begin advance_chan(); go(P_TUNE); end
                end
                P_LOCK: begin
                    m_quiet = carrier ? 0 : m_quiet + 1;
                    if (m_quiet >= HANG) begin advance_chan(); go(P_TUNE); end
                end
                P_GTX: begin
                    if (m_age >= GUARD) begin m_fre = m_table[m_chan]; m_strobe = 1'b1; go(P_TX); end
                end
                P_TX: if (!bus.ptt) go(P_GRX);
                P_GRX: begin
                    if (m_age >= GUARD) begin
                        if (bus.ptt) go(P_GTX);
                        else if (bus.scan_en && m_lockmem) begin m_quiet = 0; go(P_LOCK); end
                        else if (bus.scan_en) go(P_SETTLE);
                        else begin m_lockmem = 1'b0; go(P_IDLE); end
                    end
                end
                default: go(P_IDLE);
            endcase
        end
        if (bus.chan_we && (int'(bus.chan_addr) < CN)) m_table[bus.chan_addr] = bus.chan_fre;
    endfunction

    task automatic compare_all();
        logic exp_rx;
        exp_rx = (m_phase == P_SETTLE) || (m_phase == P_DWELL) || (m_phase == P_LOCK);
        check_eq("Fre_word",   bus.Fre_word,             m_fre);
        check_eq("cfg_strobe", 32'(bus.cfg_strobe),      32'(m_strobe));
        check_eq("rx_en",      32'(bus.rx_en),           32'(exp_rx));
        check_eq("tx_en",      32'(bus.tx_en),           32'(m_phase == P_TX));
        check_eq("locked",     32'(bus.locked),          32'(m_phase == P_LOCK));
        check_eq("chan_idx",   32'(bus.chan_idx),        32'(m_chan));
        check_eq("rx_tx_excl", 32'(bus.rx_en & bus.tx_en), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_step();
        #1;
        cyc++;
        compare_all();
    endtask

    task automatic wait_model(input int ph, input int ch, input int ag);
        int n;
        n = 0;
        while (!(m_phase == ph && m_chan == ch && m_age == ag) && n < 300) begin
            tick();
            n++;
        end
        if (n >= 300) check_eq("wait_timeout", 32'(n), 32'd0);
    endtask

    task automatic load_table();
        for (int i = 0; i < CN; i++) begin
            bus.chan_we   = 1'b1;
            bus.chan_addr = 2'(i);
            bus.chan_fre  = tbl_init[i];
            tick();
        end
        bus.chan_we = 1'b0;
    endtask

    initial begin
        int  last_strobe;
        logic carrier_on;
        RST             = 1'b1;
        bus.chan_we     = 1'b0;
        bus.chan_addr   = 2'd0;
        bus.chan_fre    = 32'd0;
        bus.scan_en     = 1'b0;
        bus.ptt         = 1'b0;
        bus.squelch_thr = 12'd100;
        bus.demod_in    = 12'd0;
        tick();
        tick();
        check_eq("rst_Fre_word", bus.Fre_word, 32'd0);
        check_eq("rst_rx_en", 32'(bus.rx_en), 32'd0);
        RST = 1'b0;
        load_table();

        // Free scan, no carrier: one retune every 11 cycles.
        bus.scan_en = 1'b1;
        last_strobe = -1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.cfg_strobe) begin
                if (last_strobe >= 0) check_eq("scan_period", 32'(cyc - last_strobe), 32'd11);
                last_strobe = cyc;
            end
        end

        // Carrier on the 3rd dwell cycle of channel 2, then hang expiry.
        wait_model(P_DWELL, 2, 2);
        bus.demod_in = 12'd150;
        tick();
        check_eq("lock_set", 32'(bus.locked), 32'd1);
        check_eq("lock_chan", 32'(bus.chan_idx), 32'd2);
        bus.demod_in = 12'd50;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("lock_hang", 32'(bus.locked), 32'd1);
        end
        tick();
        check_eq("hang_exp_locked", 32'(bus.locked), 32'd0);
        check_eq("hang_exp_chan", 32'(bus.chan_idx), 32'd3);
        tick();
        check_eq("hang_exp_strobe", 32'(bus.cfg_strobe), 32'd1);
        check_eq("hang_exp_fre", bus.Fre_word, tbl_init[3]);
        wait_model(P_DWELL, 3, 0);
        bus.demod_in = 12'd100;
        tick();
        check_eq("thr_equal_lock", 32'(bus.locked), 32'd1);
        bus.demod_in = 12'd0;

        // PTT from dwell on channel 1.
        wait_model(P_DWELL, 1, 3);
        bus.ptt = 1'b1;
        tick();
        check_eq("ptt_rx_off", 32'(bus.rx_en), 32'd0);
        tick();
        tick();
        check_eq("tx_on", 32'(bus.tx_en), 32'd1);
        check_eq("tx_fre", bus.Fre_word, 32'd459600000);
        check_eq("tx_strobe", 32'(bus.cfg_strobe), 32'd1);
        tick();
        tick();
        bus.ptt = 1'b0;
        tick();
        check_eq("grx_tx_off", 32'(bus.tx_en), 32'd0);
        tick();
        tick();
        check_eq("grx_settle_rx", 32'(bus.rx_en), 32'd1);
        check_eq("grx_settle_chan", 32'(bus.chan_idx), 32'd1);

        // One-cycle PTT coinciding with dwell expiry.
        wait_model(P_DWELL, 1, DWELL - 1);
        bus.ptt = 1'b1;
        tick();
        bus.ptt = 1'b0;
        check_eq("expiry_ptt_chan", 32'(bus.chan_idx), 32'd1);
        tick();
        tick();
        check_eq("short_tx", 32'(bus.tx_en), 32'd1);
        tick();
        check_eq("short_tx_end", 32'(bus.tx_en), 32'd0);
        tick();
        tick();
        check_eq("short_settle", 32'(bus.rx_en), 32'd1);

        // PTT from lock on channel 0; table rewrite during TX.
        wait_model(P_DWELL, 0, 0);
        bus.demod_in = 12'd150;
        tick();
        bus.ptt = 1'b1;
        tick();
        check_eq("lock_ptt_locked", 32'(bus.locked), 32'd0);
        tick();
        tick();
        check_eq("lock_tx_on", 32'(bus.tx_en), 32'd1);
        bus.chan_we   = 1'b1;
        bus.chan_addr = 2'd0;
        bus.chan_fre  = 32'd1000;
        tick();
        bus.chan_we = 1'b0;
        check_eq("tx_fre_hold", bus.Fre_word, tbl_init[0]);
        bus.ptt = 1'b0;
        tick();
        tick();
        tick();
        check_eq("relock", 32'(bus.locked), 32'd1);
        check_eq("relock_fre", bus.Fre_word, tbl_init[0]);
        bus.demod_in = 12'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("relock_hang", 32'(bus.locked), 32'd1);
        end
        tick();
        check_eq("relock_exp", 32'(bus.locked), 32'd0);
        wait_model(P_SETTLE, 0, 0);
        check_eq("new_word_tune", bus.Fre_word, 32'd1000);

        // Reset during TX, then during dwell.
        bus.ptt = 1'b1;
        wait_model(P_TX, 0, 0);
        RST     = 1'b1;
        bus.ptt = 1'b0;
        tick();
        RST = 1'b0;
        check_eq("rst_tx_tx_en", 32'(bus.tx_en), 32'd0);
        check_eq("rst_tx_fre", bus.Fre_word, 32'd0);
        wait_model(P_SETTLE, 1, 0);
        check_eq("tbl_cleared", bus.Fre_word, 32'd0);
        load_table();
        wait_model(P_DWELL, 2, 4);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_eq("rst_dwell_rx", 32'(bus.rx_en), 32'd0);
        check_eq("rst_dwell_chan", 32'(bus.chan_idx), 32'd0);
        load_table();

        // Random traffic.
        carrier_on = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) bus.squelch_thr = 12'($urandom_range(60, 200));
            bus.scan_en = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 39) == 0) bus.ptt = ~bus.ptt;
            if ($urandom_range(0, 11) == 0) carrier_on = ~carrier_on;
            bus.demod_in  = carrier_on ? 12'($urandom_range(150, 4095)) : 12'($urandom_range(0, 210));
            bus.chan_we   = ($urandom_range(0, 29) == 0);
            bus.chan_addr = 2'($urandom_range(0, CN - 1));
            bus.chan_fre  = $urandom;
            RST           = ($urandom_range(0, 699) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/chan_scan_ctrl.md
Name: chan_scan_ctrl

Overview:
Half-duplex channel scheduler for the voice transceiver. It holds a small channel table of DDS frequency words and drives the shared modem's Fre_word/center_fre. It scans channels with carrier squelch on the AM demodulator output and locks on activity. Push-to-talk takes the shared modem into transmit, with guard intervals on both transitions.

Parameters:
PHASE_WIDTH, 32, width of frequency words.
DEMOD_WIDTH, 12, width of demodulator magnitude input.
CHAN_NUM, 4, number of table entries (>=1).
DWELL_CYC, 1000, cycles listened per channel before advancing.
GUARD_CYC, 16, settle/guard cycles after retune and around TX (>=1).
HANG_CYC, 5000, cycles lock is held after carrier drops.

Ports:
clk_in  in  1  system clock.
RST  in  1  synchronous reset, active-high.
chan_we  in  1  table write strobe.
chan_addr  in  clog2(CHAN_NUM) (min 1)  table write address.
chan_fre  in  PHASE_WIDTH  table write data.
scan_en  in  1  enable receive scanning.
ptt  in  1  push-to-talk request (level).
squelch_thr  in  DEMOD_WIDTH  carrier threshold, unsigned.
demod_in  in  DEMOD_WIDTH  AM demodulator output, unsigned.
Fre_word  out  PHASE_WIDTH  frequency word to the modulator and demodulator.
cfg_strobe  out  1  one-cycle pulse when Fre_word takes a new value.
rx_en  out  1  receive path enable.
tx_en  out  1  transmit path enable.
chan_idx  out  clog2(CHAN_NUM)  current channel.
locked  out  1  carrier lock held.

Behaviour:
- Reset: all outputs 0, table entries 0, state IDLE, counters 0. RST mid-operation forces reset values at the next edge.
- Table writes apply on any cycle. A new value reaches Fre_word only at the next TUNE or TX entry. Writes with chan_addr>=CHAN_NUM are ignored.
- carrier = (demod_in >= squelch_thr), unsigned compare.
- Fre_word and cfg_strobe are registered together: cfg_strobe=1 exactly on the first cycle the new Fre_word is visible.
- Exactly one of rx_en/tx_en may be 1, or neither. Never both.
- IDLE: rx_en=0, tx_en=0.
  - ptt=1 -> GUARD_TX (ptt has priority).
  - else scan_en=1 -> TUNE.
- TUNE (1 cycle): loads Fre_word<=table[chan_idx], cfg_strobe next cycle -> SETTLE.
- SETTLE (GUARD_CYC cycles): rx_en=1, carrier is ignored -> DWELL.
- DWELL (up to DWELL_CYC cycles): rx_en=1.
  - carrier -> LOCK on the next cycle.
  - Counter expiry without carrier: chan_idx advances (CHAN_NUM-1 wraps to 0; CHAN_NUM=1 stays 0) -> TUNE.
- LOCK: rx_en=1, locked=1.
  - The hang counter loads HANG_CYC on entry and on every carrier cycle; otherwise it decrements.
  - At 0: locked=0, chan_idx advances -> TUNE.
- scan_en=0 in TUNE/SETTLE/DWELL/LOCK -> IDLE next cycle. chan_idx holds, locked clears, Fre_word holds.
- ptt=1 in any RX state (TUNE/SETTLE/DWELL/LOCK) -> GUARD_TX.
  - chan_idx is not advanced, even if dwell or hang expires in the same cycle.
  - locked is remembered internally as lock_mem and cleared on the output.
- GUARD_TX (GUARD_CYC cycles): both enables 0. Not abortable.
  - On exit, Fre_word reloads table[chan_idx] with cfg_strobe -> TX.
- TX: tx_en=1 while ptt=1.
  - ptt=0 (including already 0 at TX entry, giving a one-cycle TX) -> GUARD_RX.
- GUARD_RX (GUARD_CYC cycles): both enables 0. A ptt re-assert during GUARD_RX is honoured only at its end.
  - ptt=1 -> GUARD_TX.
  - scan_en=1 and lock_mem=1 -> LOCK (hang reloaded).
  - scan_en=1 and lock_mem=0 -> SETTLE.
  - otherwise -> IDLE.
- Counters are sized clog2(max(DWELL_CYC,HANG_CYC,GUARD_CYC)+1) and never wrap unintentionally.

Decomposition:
- Shared package: state enumeration (IDLE, TUNE, SETTLE, DWELL, LOCK, GUARD_TX, TX, GUARD_RX), plus clog2-derived width constants for chan_idx and counters.
- One natural sub-module: chan_table (CHAN_NUM x PHASE_WIDTH register file, sync write, async read, sync reset).
- FSM, counters and output registers stay in the top.

Test Plan:
Bench params are CHAN_NUM=4, DWELL_CYC=8, GUARD_CYC=2, HANG_CYC=4, squelch_thr=100. Table = {459561501, 459600000, 459700000, 459800000}.
1. Reset, load table, scan_en=1, demod_in=0 -> Fre_word steps through all four words with a one-cycle cfg_strobe each. Per-channel period is 11 cycles (1 TUNE + 2 SETTLE + 8 DWELL). chan_idx wraps 3->0. rx_en=1 except on TUNE cycles.
2. While on chan 2, drive demod_in=150 on the 3rd DWELL cycle -> locked=1 next cycle, chan_idx=2. Drop to 50 -> locked holds 4 cycles, then clears, chan_idx=3, cfg_strobe. demod_in=100 exactly also counts as carrier.
3. During DWELL on chan 1, raise ptt -> rx_en=0 next cycle. After 2 cycles: tx_en=1, Fre_word=459600000, cfg_strobe. Release ptt -> tx_en=0, 2 guard cycles, then SETTLE on chan 1 (rx_en=1). chan_idx stays 1 throughout.
4. ptt asserted on the same cycle the dwell counter expires -> chan_idx not advanced. ptt pulse of 1 cycle -> full 2-cycle GUARD_TX, 1-cycle TX, GUARD_RX.
5. PTT from LOCK on chan 0 -> after TX and GUARD_RX, returns to LOCK with locked=1 and hang reloaded to 4. Rewrite table[0]=1000 while in TX -> Fre_word unchanged until the next TUNE.
6. RST pulsed during TX and during DWELL -> next cycle all outputs 0, table cleared, state IDLE. Bench also asserts (rx_en & tx_en) is never 1 in any scenario.
